// File: rtl/axi_r_pkg.sv
// Shared types and constants for the slave-side AXI read-burst engine.
package axi_r_pkg;

  localparam int unsigned ID_W     = 8;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned SIZE_W   = 3;
  localparam int unsigned BURST_W  = 2;
  localparam int unsigned RESP_W   = 2;
  localparam int unsigned R_BEAT_W = ID_W + DATA_W + RESP_W + 1;

  typedef enum logic [BURST_W-1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  // First byte address outside the decoded SRAM range.
  localparam logic [ADDR_W-1:0] DECERR_BASE = 32'h0001_0000;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;
  } r_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10
  } r_state_t;

  // Request-level protocol violations that force SLVERR on every beat.
  function automatic logic req_slverr(input logic [LEN_W-1:0]   len,
                                      input logic [SIZE_W-1:0]  size,
                                      input logic [BURST_W-1:0] burst);
    logic wrap_ok;
    wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (burst == 2'b11) || (size > 3'd2) || ((burst == WRAP) && !wrap_ok);
  endfunction

  // Address of the beat following addr under the given burst rules.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0]  addr,
                                                  input logic [LEN_W-1:0]   len,
                                                  input logic [SIZE_W-1:0]  size,
                                                  input logic [BURST_W-1:0] burst);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = (addr & ~mask) | ((addr + step) & mask);
      default: next_addr = addr + step;
    endcase
  endfunction

endpackage

// File: rtl/r_beat_gen_slave_if.sv
// AR request, SRAM read port and R-FIFO write port of the read-burst engine.
interface r_beat_gen_slave_if;
  import axi_r_pkg::*;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [LEN_W-1:0]    arlen;
  logic [SIZE_W-1:0]   arsize;
  logic [BURST_W-1:0]  arburst;
  logic                arvalid;
  logic                arready;

  logic                mem_cs;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_rdata;

  logic                fifo_wpush;
  logic [R_BEAT_W-1:0] fifo_wdata;
  logic                fifo_wfull;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output mem_cs, mem_addr,
    input  mem_rdata,
    output fifo_wpush, fifo_wdata,
    input  fifo_wfull
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  mem_cs, mem_addr,
    output mem_rdata,
    input  fifo_wpush, fifo_wdata,
    output fifo_wfull
  );
endinterface

// File: rtl/r_beat_skid.sv
// Two-entry single-clock beat buffer between the SRAM return path and the R FIFO.
module r_beat_skid
  import axi_r_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  r_beat_t    push_beat,
  input  logic       pop,
  output r_beat_t    head,
  output logic [1:0] count
);

  r_beat_t entry [2];
  logic    wptr;
  logic    rptr;
  logic    do_push;
  logic    do_pop;

  // A full buffer only takes a new beat when the head leaves in the same cycle.
  assign do_push = push && ((count != 2'd2) || pop);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = entry[rptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        entry[wptr] <= push_beat;
        wptr        <= ~wptr;
      end
      if (do_pop) begin
        rptr <= ~rptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/r_beat_gen_slave.sv
// Slave-side AXI read-burst engine: one AR burst at a time, SRAM reads with
// 1-cycle latency, beats packed as {id,data,resp,last} into the R CDC FIFO.
// Optional build macro R_BEAT_GEN_DECERR_EN: beats addressed at or above
// 0x0001_0000 return DECERR with zero data and no SRAM access.
module r_beat_gen_slave
  import axi_r_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  r_beat_gen_slave_if.slave  bus
);

  r_state_t           state;
  logic               arready_q;
  logic [ID_W-1:0]    id_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [SIZE_W-1:0]  size_q;
  logic [BURST_W-1:0] burst_q;
  logic               slverr_q;
  logic [LEN_W-1:0]   beat_cnt;

  // Beat issued last cycle; its SRAM data (if any) is on mem_rdata now.
  logic               inf_vld;
  logic               inf_zero;
  logic               inf_last;
  logic [RESP_W-1:0]  inf_resp;

  logic [1:0]         buf_cnt;
  r_beat_t            head;
  r_beat_t            fill_beat_c;
  logic               pop_c;
  logic [2:0]         occ_c;
  logic               issue_c;
  logic [RESP_W-1:0]  beat_resp_c;
  logic               beat_zero_c;
  logic               handshake_c;

  assign handshake_c = bus.arvalid && arready_q;
  assign pop_c       = (buf_cnt != 2'd0) && !bus.fifo_wfull;
  // Slots already committed once this cycle's pop is accounted for.
  assign occ_c       = 3'(buf_cnt) + 3'(inf_vld) - 3'(pop_c);
  assign issue_c     = (state == ISSUE) && (occ_c < 3'd2);
  assign beat_zero_c = (beat_resp_c != RESP_OKAY);

  // Response of the beat at the current address.
  always_comb begin
    beat_resp_c = RESP_OKAY;
    if (slverr_q) begin
      beat_resp_c = RESP_SLVERR;
    end
`ifdef R_BEAT_GEN_DECERR_EN
    else if (addr_q >= DECERR_BASE) begin
      beat_resp_c = RESP_DECERR;
    end
`endif
  end

  // Assemble the beat landing in the buffer this cycle.
  always_comb begin
    fill_beat_c      = '0;
    fill_beat_c.id   = id_q;
    fill_beat_c.data = inf_zero ? '0 : bus.mem_rdata;
    fill_beat_c.resp = inf_resp;
    fill_beat_c.last = inf_last;
  end

  // Burst control: request latch, issue sequencing and drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      slverr_q  <= 1'b0;
      beat_cnt  <= '0;
      inf_vld   <= 1'b0;
      inf_zero  <= 1'b0;
      inf_last  <= 1'b0;
      inf_resp  <= RESP_OKAY;
    end else begin
      inf_vld  <= issue_c;
      inf_zero <= beat_zero_c;
      inf_last <= (beat_cnt == len_q);
      inf_resp <= beat_resp_c;
      case (state)
        IDLE: begin
          arready_q <= 1'b1;
          if (handshake_c) begin
            arready_q <= 1'b0;
            id_q      <= bus.arid;
            addr_q    <= bus.araddr;
            len_q     <= bus.arlen;
            size_q    <= bus.arsize;
            burst_q   <= bus.arburst;
            slverr_q  <= req_slverr(bus.arlen, bus.arsize, bus.arburst);
            beat_cnt  <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_c) begin
            addr_q   <= next_addr(addr_q, len_q, size_q, burst_q);
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (beat_cnt == len_q) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!inf_vld && (buf_cnt == 2'd0)) begin
            state     <= IDLE;
            arready_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          arready_q <= 1'b0;
        end
      endcase
    end
  end

  r_beat_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inf_vld),
    .push_beat (fill_beat_c),
    .pop       (pop_c),
    .head      (head),
    .count     (buf_cnt)
  );

  assign bus.arready    = arready_q;
  // Gated by the live credit so the buffer sustains one beat per cycle.
  assign bus.mem_cs     = issue_c && !beat_zero_c;
  assign bus.mem_addr   = addr_q;
  assign bus.fifo_wpush = (buf_cnt != 2'd0);
  assign bus.fifo_wdata = head;

endmodule
